serial_adder: RTL and testbench

//   Parametrised bit-serial adder/subtractor; successor to the combinational half/full adder cells.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/fa.sv | 18 +
 rtl/ha.sv | 12 +
 rtl/serial_adder.sv | 125 ++++++++++++
 tb/tb_serial_adder.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the operation-mode encoding used on the mode input.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/fa.sv
// One-bit full adder made from two half adders; the carry out is the OR of
// the two partial carries (they can never both be high).
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0, c0, c1;

  ha u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  ha u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;

endmodule

// File: rtl/ha.sv
// One-bit half adder cell, the building block of the full adder.
module ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: operands are consumed LSB-first through a
// single full-adder cell, one bit per clock, under a start/busy/done
// handshake. Subtraction is a + ~b + 1, so the carry flop is preset to 1.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state, state_d;
  logic accept, last_bit;

  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] acc_shift;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             bit_s, bit_c;

  fa u_fa (
    .a (op_a[0]),
    .b (op_b[0]),
    .ci(carry),
    .s (bit_s),
    .co(bit_c)
  );

  // Accumulated result bits with the newest sum bit entering at the MSB.
  assign acc_shift = {bit_s, acc};

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state plus the accept / final-bit strobes for the datapath.
  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    last_bit = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          accept  = 1'b1;
        end
      end
      S_RUN: begin
        if (cnt == CNT_LAST) begin
          state_d  = S_DONE;
          last_bit = 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          accept  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand/accumulator shift registers, carry flop and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= (mode == MODE_SUB) ? ~b : b;
      carry <= (mode == MODE_ADD) ? 1'b0 : 1'b1;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      op_a  <= {1'b0, op_a[WIDTH-1:1]};
      op_b  <= {1'b0, op_b[WIDTH-1:1]};
      acc   <= acc_shift[WIDTH-1:1];
      carry <= bit_c;
      if (!last_bit) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Result registers, updated only on the MSB step so they hold between ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (last_bit) begin
      sum  <= acc_shift;
      cout <= bit_c;
      ovf  <= carry ^ bit_c;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit instance exercised with a
// vector table, random operands and handshake corner cases, and a 4-bit
// instance checked exhaustively against an arithmetic reference model.
module tb_serial_adder;
  import serial_adder_pkg::*;

  logic       clk, rst_n;
  logic       start8, mode8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start4, mode4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

  int tests;
  int failures;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs [7];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference: modulo result, unsigned carry/no-borrow and
  // signed overflow judged by whether the true signed result fits in w bits.
  function automatic void refModel(input int w, input longint av, input longint bv, input bit m,
                                   output longint s, output bit co, output bit ov);
    longint full = longint'(1) << w;
    longint half = full / 2;
    longint sa   = (av >= half) ? av - full : av;
    longint sb   = (bv >= half) ? bv - full : bv;
    longint r    = m ? sa - sb : sa + sb;
    s  = (m ? av - bv : av + bv) & (full - 1);
    co = m ? (av >= bv) : (av + bv >= full);
    ov = (r < -half) || (r >= half);
  endfunction

  // Launch one operation on the chosen DUT and count edges until done.
  task automatic applyStimulus(input bit narrow, input logic [31:0] av, input logic [31:0] bv,
                               input logic m, output int edges);
    @(negedge clk);
    if (narrow) begin
      a4 = av[3:0]; b4 = bv[3:0]; mode4 = m; start4 = 1'b1;
    end else begin
      a8 = av[7:0]; b8 = bv[7:0]; mode8 = m; start8 = 1'b1;
    end
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    edges = 0;
    while (!(narrow ? done4 : done8) && edges < 64) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic checkResult(input string name, input bit narrow, input logic [31:0] av,
                             input logic [31:0] bv, input logic m);
    longint     es;
    bit         ec, eo;
    logic [31:0] act_sum;
    refModel(narrow ? 4 : 8, longint'(av), longint'(bv), m, es, ec, eo);
    act_sum = narrow ? 32'(sum4) : 32'(sum8);
    checkOutput({name, "_sum"},  64'(act_sum), 64'(es));
    checkOutput({name, "_cout"}, 64'(narrow ? cout4 : cout8), 64'(ec));
    checkOutput({name, "_ovf"},  64'(narrow ? ovf4 : ovf8), 64'(eo));
  endtask

  // Main test sequence.
  initial begin
    int          edges;
    int          pulses;
    logic [31:0] av, bv;
    logic        m;

    tests = 0;
    failures = 0;
    rst_n = 1'b0;
    start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; mode4 = 1'b0; a4 = '0; b4 = '0;

    vecs[0] = '{a: 8'h05, b: 8'h03, mode: MODE_ADD, sum: 8'h08, cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'h7F, b: 8'h01, mode: MODE_ADD, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'h01, mode: MODE_ADD, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 8'h03, b: 8'h05, mode: MODE_SUB, sum: 8'hFE, cout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h01, mode: MODE_SUB, sum: 8'h7F, cout: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 8'h80, b: 8'h80, mode: MODE_ADD, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
    vecs[6] = '{a: 8'h5A, b: 8'h5A, mode: MODE_SUB, sum: 8'h00, cout: 1'b1, ovf: 1'b0};

    #15 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", 64'(busy8), 64'd0);
    checkOutput("reset_done", 64'(done8), 64'd0);
    checkOutput("reset_sum",  64'(sum8),  64'd0);
    checkOutput("reset_cout", 64'(cout8), 64'd0);
    checkOutput("reset_ovf",  64'(ovf8),  64'd0);
    checkOutput("reset_w4",   64'({busy4, done4, sum4, cout4, ovf4}), 64'd0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].mode, edges);
      checkOutput($sformatf("vec%0d_latency", i), 64'(edges), 64'd8);
      checkOutput($sformatf("vec%0d_busy_in_done", i), 64'(busy8), 64'd0);
      checkOutput($sformatf("vec%0d_sum", i),  64'(sum8),  64'(vecs[i].sum));
      checkOutput($sformatf("vec%0d_cout", i), 64'(cout8), 64'(vecs[i].cout));
      checkOutput($sformatf("vec%0d_ovf", i),  64'(ovf8),  64'(vecs[i].ovf));
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_pulse", i), 64'(done8), 64'd0);
    end

    for (int i = 0; i < 40; i++) begin
      av = 32'($urandom_range(0, 255));
      bv = 32'($urandom_range(0, 255));
      m  = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, av, bv, m, edges);
      checkOutput($sformatf("rand%0d_latency", i), 64'(edges), 64'd8);
      checkResult($sformatf("rand%0d", i), 1'b0, av, bv, m);
    end

    // start while busy is ignored: the first operation's result stands
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; mode8 = MODE_ADD; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    edges = 0;
    repeat (3) begin
      @(negedge clk);
      edges++;
    end
    a8 = 8'hAA; b8 = 8'h55; mode8 = MODE_SUB; start8 = 1'b1;
    @(negedge clk);
    edges++;
    start8 = 1'b0;
    while (!done8 && edges < 64) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("busy_start_latency", 64'(edges), 64'd8);
    checkOutput("busy_start_sum", 64'(sum8), 64'h46);
    @(negedge clk);
    checkOutput("busy_start_not_queued", 64'(busy8), 64'd0);

    // start in the DONE cycle: next operation begins without an IDLE gap
    applyStimulus(1'b0, 32'h10, 32'h20, MODE_ADD, edges);
    checkOutput("b2b_first_sum", 64'(sum8), 64'h30);
    a8 = 8'h05; b8 = 8'h07; mode8 = MODE_SUB; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("b2b_no_gap_busy", 64'(busy8), 64'd1);
    checkOutput("b2b_done_dropped", 64'(done8), 64'd0);
    checkOutput("b2b_sum_held", 64'(sum8), 64'h30);
    edges = 0;
    while (!done8 && edges < 64) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("b2b_second_latency", 64'(edges), 64'd8);
    checkResult("b2b_second", 1'b0, 32'h05, 32'h07, MODE_SUB);

    // reset in the middle of RUN aborts the operation
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; mode8 = MODE_ADD; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_sum",  64'(sum8),  64'd0);
    checkOutput("midreset_busy", 64'(busy8), 64'd0);
    checkOutput("midreset_flags", 64'({done8, cout8, ovf8}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) pulses++;
    end
    checkOutput("midreset_no_done", 64'(pulses), 64'd0);
    checkOutput("midreset_sum_after", 64'(sum8), 64'd0);

    // exhaustive check of the 4-bit instance
    for (int mm = 0; mm < 2; mm++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          applyStimulus(1'b1, 32'(ia), 32'(ib), 1'(mm), edges);
          checkOutput($sformatf("w4_%0d_%0d_%0d_latency", mm, ia, ib), 64'(edges), 64'd4);
          checkResult($sformatf("w4_%0d_%0d_%0d", mm, ia, ib), 1'b1, 32'(ia), 32'(ib), 1'(mm));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
